// File: rtl/clint_timer_pkg.sv
// Package for the core-local interruptor (CLINT).
// Purpose: shared configuration constants, register-select type and a
// byte-enable merge helper used by the CLINT top level.
// Contents:
//   clk_divider_rtc     default RTC tick divider (tick every value+1 clocks)
//   clint_harts         default number of harts
//   clint_*_off         16-bit register window offsets inside the CLINT
//   reg_sel_e           decoded register class of a bus request
//   merge_bytes()       applies a 4-bit byte enable to a 32-bit word
package clint_timer_pkg;

   localparam int clk_divider_rtc = 4;
   localparam int clint_harts     = 1;

   localparam logic [15:0] clint_msip_off     = 16'h0000;
   localparam logic [15:0] clint_mtimecmp_off = 16'h4000;
   localparam logic [15:0] clint_mtime_off    = 16'hBFF8;

   typedef enum logic [1:0] {
      REG_NONE     = 2'd0,
      REG_MSIP     = 2'd1,
      REG_MTIMECMP = 2'd2,
      REG_MTIME    = 2'd3
   } reg_sel_e;

   // Replace only the bytes whose enable bit is set.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = new_word[b*8 +: 8];
         end else begin
            res[b*8 +: 8] = old_word[b*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_timer_rtc.sv
// RTC tick generator for the CLINT.
// Purpose: counts 0..RTC_DIV and raises o_tick on the cycle the count equals
// RTC_DIV, then wraps to 0. RTC_DIV = 0 gives a tick every clock.
// Ports:
//   i_clock  system clock
//   i_reset  synchronous active-high reset (counter returns to 0)
//   o_tick   one-cycle tick strobe
module clint_rtc
   import clint_timer_pkg::*;
#(
   parameter int RTC_DIV = clk_divider_rtc
) (
   input  logic i_clock,
   input  logic i_reset,
   output logic o_tick
);

   localparam int CW = (RTC_DIV > 0) ? $clog2(RTC_DIV + 1) : 1;
   localparam logic [CW-1:0] DIV_MAX = CW'(RTC_DIV);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [CW-1:0] r_cnt;
   logic          w_at_max;

   assign w_at_max = (r_cnt == DIV_MAX);
   assign o_tick   = w_at_max;

   // Divider counter: wraps to zero on the tick cycle.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cnt <= {CW{1'b0}};
      end else if (w_at_max) begin
         r_cnt <= {CW{1'b0}};
      end else begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: per-hart msip and mtimecmp plus shared 64-bit mtime.
// Purpose: memory-mapped timer/software interrupt block with a one-cycle,
// never-stalling request/response handshake.
// Ports:
//   i_clock, i_reset             clock, synchronous active-high reset
//   i_mem_valid/addr/wdata/wstrb request (wstrb == 0 means read)
//   o_mem_rdata, o_mem_ready     response one cycle after the request
//   o_msip[HARTS]                software interrupt pending per hart
//   o_mtip[HARTS]                timer interrupt pending per hart
module clint_timer
   import clint_timer_pkg::*;
#(
   parameter int HARTS   = clint_harts,
   parameter int RTC_DIV = clk_divider_rtc
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_mem_valid,
   input  logic [31:0]      i_mem_addr,
   input  logic [31:0]      i_mem_wdata,
   input  logic [3:0]       i_mem_wstrb,
   output logic [31:0]      o_mem_rdata,
   output logic             o_mem_ready,
   output logic [HARTS-1:0] o_msip,
   output logic [HARTS-1:0] o_mtip
);

   localparam int          HW      = (HARTS > 1) ? $clog2(HARTS) : 1;
   localparam logic [15:0] HARTS16 = 16'(HARTS);

   logic [63:0]      r_mtime;
   logic [63:0]      r_mtimecmp [HARTS];
   logic [HARTS-1:0] r_msip;
   logic [HARTS-1:0] r_mtip;
   logic             r_ready;
   logic [31:0]      r_rdata;

   logic             w_tick;
   logic             w_wr;
   logic [15:0]      w_off;
   logic [15:0]      w_msip_idx;
   logic [15:0]      w_cmp_idx;
   logic [HW-1:0]    w_idx;
   logic             w_hi;
   reg_sel_e         w_sel;
   logic [31:0]      w_rdata;
   logic [HARTS-1:0] w_ge;

   clint_rtc #(.RTC_DIV(RTC_DIV)) u_rtc (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .o_tick  (w_tick)
   );

   assign w_off      = i_mem_addr[15:0];
   assign w_wr       = i_mem_valid && (i_mem_wstrb != 4'd0);
   assign w_hi       = w_off[2];
   assign w_msip_idx = (w_off - clint_msip_off) >> 2;
   assign w_cmp_idx  = (w_off - clint_mtimecmp_off) >> 3;

   // Address decode: out-of-range hart indices fall through to REG_NONE.
   always_comb begin
      w_sel = REG_NONE;
      w_idx = {HW{1'b0}};
      if ((w_off < clint_mtimecmp_off) && (w_msip_idx < HARTS16)) begin
         w_sel = REG_MSIP;
         w_idx = w_msip_idx[HW-1:0];
      end else if ((w_off >= clint_mtimecmp_off) && (w_cmp_idx < HARTS16)) begin
         w_sel = REG_MTIMECMP;
         w_idx = w_cmp_idx[HW-1:0];
      end else if (w_off[15:3] == clint_mtime_off[15:3]) begin
         w_sel = REG_MTIME;
      end else begin
         w_sel = REG_NONE;
      end
   end

   // Read data mux; unmapped locations read as zero.
   always_comb begin
      w_rdata = 32'd0;
      case (w_sel)
         REG_MSIP:     w_rdata = {31'd0, r_msip[w_idx]};
         REG_MTIMECMP: w_rdata = w_hi ? r_mtimecmp[w_idx][63:32] : r_mtimecmp[w_idx][31:0];
         REG_MTIME:    w_rdata = w_hi ? r_mtime[63:32] : r_mtime[31:0];
         default:      w_rdata = 32'd0;
      endcase
   end

   // Per-hart unsigned 64-bit compare feeding the registered mtip.
   for (genvar g = 0; g < HARTS; g++) begin : g_cmp
      assign w_ge[g] = (r_mtime >= r_mtimecmp[g]);
   end

   // Bus response, register writes, mtime advance and mtip update.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_ready <= 1'b0;
         r_rdata <= 32'd0;
         r_mtime <= 64'd0;
         r_msip  <= {HARTS{1'b0}};
         r_mtip  <= {HARTS{1'b0}};
         for (int h = 0; h < HARTS; h++) begin
            r_mtimecmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
         end
      end else begin
         r_ready <= i_mem_valid;
         if (i_mem_valid && !w_wr) begin
            r_rdata <= w_rdata;
         end else begin
            r_rdata <= 32'd0;
         end

         // A software write to either half suppresses that cycle's increment;
         // a low-word write never carries into the high word.
         if (w_wr && (w_sel == REG_MTIME)) begin
            if (w_hi) begin
               r_mtime[63:32] <= merge_bytes(r_mtime[63:32], i_mem_wdata, i_mem_wstrb);
            end else begin
               r_mtime[31:0]  <= merge_bytes(r_mtime[31:0], i_mem_wdata, i_mem_wstrb);
            end
         end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
         end

         if (w_wr && (w_sel == REG_MSIP) && i_mem_wstrb[0]) begin
            r_msip[w_idx] <= i_mem_wdata[0];
         end

         if (w_wr && (w_sel == REG_MTIMECMP)) begin
            if (w_hi) begin
               r_mtimecmp[w_idx][63:32] <= merge_bytes(r_mtimecmp[w_idx][63:32], i_mem_wdata, i_mem_wstrb);
            end else begin
               r_mtimecmp[w_idx][31:0]  <= merge_bytes(r_mtimecmp[w_idx][31:0], i_mem_wdata, i_mem_wstrb);
            end
         end

         r_mtip <= w_ge;
      end
   end

   assign o_mem_ready = r_ready;
   assign o_mem_rdata = r_rdata;
   assign o_msip      = r_msip;
   assign o_mtip      = r_mtip;

endmodule

// File: tb/tb_clint_timer.sv
// Directed self-checking bench for clint_timer with HARTS=2, RTC_DIV=4.
// Every bus access occupies exactly one clock: inputs are driven at a falling
// edge, sampled on the next rising edge (edge E<n>, counted from reset
// release), and the response is checked at the following falling edge.
// With RTC_DIV=4 the RTC ticks on edges E4, E9, E14, ... (n % 5 == 4).
module tb_clint_timer;

   logic        clk;
   logic        reset;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [1:0]  msip;
   logic [1:0]  mtip;

   int n_checks = 0;
   int n_fail   = 0;

   clint_timer #(.HARTS(2), .RTC_DIV(4)) dut (
      .i_clock     (clk),
      .i_reset     (reset),
      .i_mem_valid (mem_valid),
      .i_mem_addr  (mem_addr),
      .i_mem_wdata (mem_wdata),
      .i_mem_wstrb (mem_wstrb),
      .o_mem_rdata (mem_rdata),
      .o_mem_ready (mem_ready),
      .o_msip      (msip),
      .o_mtip      (mtip)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request cycle; returns at the falling edge after the sampling edge.
   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = d;
      mem_wstrb = s;
      @(posedge clk);
      @(negedge clk);
      mem_valid = 1'b0;
      mem_wstrb = 4'd0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      bus(a, 32'd0, 4'd0);
      chk({tag, "_rdy"}, {31'd0, mem_ready}, 32'd1);
      chk(tag, mem_rdata, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
      bus(a, d, s);
      chk({tag, "_rdy"}, {31'd0, mem_ready}, 32'd1);
      chk({tag, "_rdata0"}, mem_rdata, 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      mem_valid = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_wstrb = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, mem_ready}, 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      chk("rst_msip", {30'd0, msip}, 32'd0);
      chk("rst_mtip", {30'd0, mtip}, 32'd0);
      reset = 1'b0;

      // Reset values over the bus (E0..E3)
      rd(32'h0000_BFF8, 32'd0, "rst_mtime_lo");
      rd(32'h0000_4000, 32'hFFFF_FFFF, "rst_cmp0_lo");
      rd(32'h0000_4004, 32'hFFFF_FFFF, "rst_cmp0_hi");
      rd(32'h0000_0000, 32'd0, "rst_msip0_rd");

      // mtime rate: value before E4 is 0, before E5 is 1, before E50 is 10
      rd(32'h0000_BFF8, 32'd0, "mtime_e4");
      rd(32'h0000_BFF8, 32'd1, "mtime_e5");
      repeat (44) @(negedge clk);
      rd(32'h0000_BFF8, 32'd10, "mtime_e50");
      rd(32'h0000_BFF8, 32'd10, "mtime_e51");

      // mtimecmp[1] = 20; mtime reaches 20 on E99, mtip[1] rises on E100
      wr(32'h0000_4008, 32'd20, 4'hF, "cmp1_lo");
      wr(32'h0000_400C, 32'd0, 4'hF, "cmp1_hi");
      repeat (46) @(negedge clk);
      chk("mtip_before", {30'd0, mtip}, 32'd0);
      @(negedge clk);
      chk("mtip1_rise", {30'd0, mtip}, 32'd2);

      // Carry across halves via tick at E104
      wr(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, "mt_lo_ones");
      wr(32'h0000_BFFC, 32'd0, 4'hF, "mt_hi_zero");
      repeat (2) @(negedge clk);
      rd(32'h0000_BFF8, 32'd0, "carry_lo");
      rd(32'h0000_BFFC, 32'd1, "carry_hi");

      // All-ones wraps to 0 at E109
      wr(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, "wrap_lo");
      wr(32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF, "wrap_hi");
      chk("wrap_mtip_pre", {30'd0, mtip}, 32'd2);
      @(negedge clk);
      chk("wrap_mtip_ones", {30'd0, mtip}, 32'd3);
      rd(32'h0000_BFF8, 32'd0, "wrap_mtime_lo");
      chk("wrap_mtip_clear", {30'd0, mtip}, 32'd0);

      // msip byte-enable behaviour
      wr(32'h0000_0000, 32'hFFFF_FFFF, 4'h1, "msip0_set");
      chk("msip0_vis", {30'd0, msip}, 32'd1);
      rd(32'h0000_0000, 32'd1, "msip0_rd");
      wr(32'h0000_0000, 32'd0, 4'h2, "msip0_strb2");
      chk("msip0_hold", {30'd0, msip}, 32'd1);
      rd(32'h0000_0000, 32'd1, "msip0_rd2");
      wr(32'h0000_0004, 32'd1, 4'hF, "msip1_set");
      chk("msip1_vis", {30'd0, msip}, 32'd3);

      // mtime write in a tick cycle (E119) wins over the increment
      repeat (3) @(negedge clk);
      wr(32'h0000_BFF8, 32'h0000_0100, 4'hF, "tick_wr");
      rd(32'h0000_BFF8, 32'h0000_0100, "tick_wr_lo");
      rd(32'h0000_BFFC, 32'd0, "tick_wr_hi");

      // Out-of-range hart, high address bits, unmapped offset
      rd(32'h0000_0008, 32'd0, "hart2_rd");
      wr(32'h0000_0008, 32'd0, 4'hF, "hart2_wr");
      chk("hart2_wr_ign", {30'd0, msip}, 32'd3);
      rd(32'h0001_4000, 32'hFFFF_FFFF, "alias_cmp0");
      rd(32'h0000_8000, 32'd0, "unmapped_rd");
      @(negedge clk);
      chk("idle_ready", {31'd0, mem_ready}, 32'd0);
      chk("idle_rdata", mem_rdata, 32'd0);

      // Reset arriving with a request pending
      mem_valid = 1'b1;
      mem_addr  = 32'h0000_BFF8;
      mem_wstrb = 4'd0;
      reset     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_valid = 1'b0;
      chk("mid_rst_ready", {31'd0, mem_ready}, 32'd0);
      chk("mid_rst_rdata", mem_rdata, 32'd0);
      chk("mid_rst_msip", {30'd0, msip}, 32'd0);
      chk("mid_rst_mtip", {30'd0, mtip}, 32'd0);
      reset = 1'b0;
      rd(32'h0000_4008, 32'hFFFF_FFFF, "mid_rst_cmp1");
      rd(32'h0000_BFF8, 32'd0, "mid_rst_mtime");

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
